// File: rtl/regfile_ctrl_pkg.sv
// Shared types for regfile_access_ctrl: default widths, read FSM states
// and the write-queue entry layout.
package regfile_ctrl_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPT,
    RESP
  } rd_state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] rd;
    logic [DEF_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/regfile_wr_queue.sv
// Writeback FIFO for regfile_access_ctrl. Besides the head it presents every
// entry in age order (index 0 = oldest) with a valid bit for forwarding.
module regfile_wr_queue
  import regfile_ctrl_pkg::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = wr_entry_t
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               push,
  input  entry_t             push_entry,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output entry_t             head,
  output entry_t [DEPTH-1:0] entries,
  output logic   [DEPTH-1:0] valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t [DEPTH-1:0] mem;
  logic   [PW-1:0]    wptr;
  logic   [PW-1:0]    rptr;
  logic   [CW-1:0]    count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= push_entry;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) begin
        rptr <= rptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_comb begin
    entries = '0;
    valid   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[rptr + PW'(i)];
      valid[i]   = (CW'(i) < count);
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file port owner: sequences operand reads with queue forwarding and
// drains buffered writebacks. Define REGFILE_ZERO_REG_EN to hardwire r0 to zero.
module regfile_access_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_rs1,
  input  logic [ADDR_W-1:0] rd_req_rs2,
  output logic              rd_rsp_valid,
  input  logic              rd_rsp_ready,
  output logic [DATA_W-1:0] rd_rsp_data1,
  output logic [DATA_W-1:0] rd_rsp_data2,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_rd,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic [ADDR_W-1:0] rf_read_reg1,
  output logic [ADDR_W-1:0] rf_read_reg2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write
);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  rd_state_t                state;
  rd_state_t                state_nxt;
  logic                     rd_fire;
  logic                     freeze;
  logic                     wr_enq;
  logic                     q_full;
  logic                     q_empty;
  entry_t                   q_head;
  entry_t                   push_entry;
  entry_t [WQ_DEPTH-1:0]    q_entries;
  logic   [WQ_DEPTH-1:0]    q_valid;
  logic                     hit1, hit2, hit1_q, hit2_q;
  logic [DATA_W-1:0]        fwd1, fwd2, fwd1_q, fwd2_q;
  logic [DATA_W-1:0]        cap1, cap2;

  assign rd_fire      = rd_req_valid && rd_req_ready;
  assign wr_req_ready = resetn && !q_full && !freeze;
  assign push_entry   = '{rd: wr_req_rd, data: wr_req_data};
`ifdef REGFILE_ZERO_REG_EN
  assign wr_enq = wr_req_valid && wr_req_ready && (wr_req_rd != '0);
`else
  assign wr_enq = wr_req_valid && wr_req_ready;
`endif

  assign rf_write      = !q_empty && !freeze;
  assign rf_write_reg  = rf_write ? q_head.rd : '0;
  assign rf_write_data = rf_write ? q_head.data : '0;

  regfile_wr_queue #(
    .DEPTH   (WQ_DEPTH),
    .entry_t (entry_t)
  ) u_wr_queue (
    .clk        (clk),
    .resetn     (resetn),
    .push       (wr_enq),
    .push_entry (push_entry),
    .pop        (rf_write),
    .full       (q_full),
    .empty      (q_empty),
    .head       (q_head),
    .entries    (q_entries),
    .valid      (q_valid)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (rd_fire) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPT;
      CAPT:    state_nxt = RESP;
      RESP:    if (rd_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rd_req_ready = resetn && (state == IDLE);
    rd_rsp_valid = (state == RESP);
    freeze       = (state == ISSUE);
  end

  // Entries are age ordered, so a later match (younger write) overrides.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      if (q_valid[i] && (q_entries[i].rd == rf_read_reg1)) begin
        hit1 = 1'b1;
        fwd1 = q_entries[i].data;
      end
      if (q_valid[i] && (q_entries[i].rd == rf_read_reg2)) begin
        hit2 = 1'b1;
        fwd2 = q_entries[i].data;
      end
    end
  end

  always_comb begin
    cap1 = hit1_q ? fwd1_q : rf_read_data1;
    cap2 = hit2_q ? fwd2_q : rf_read_data2;
`ifdef REGFILE_ZERO_REG_EN
    if (rf_read_reg1 == '0) cap1 = '0;
    if (rf_read_reg2 == '0) cap2 = '0;
`endif
  end

  // Queue is frozen during ISSUE, so the snapshot taken there is exact.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_read_reg1 <= '0;
      rf_read_reg2 <= '0;
      hit1_q       <= 1'b0;
      hit2_q       <= 1'b0;
      fwd1_q       <= '0;
      fwd2_q       <= '0;
      rd_rsp_data1 <= '0;
      rd_rsp_data2 <= '0;
    end else begin
      if (rd_fire) begin
        rf_read_reg1 <= rd_req_rs1;
        rf_read_reg2 <= rd_req_rs2;
      end
      if (state == ISSUE) begin
        hit1_q <= hit1;
        hit2_q <= hit2;
        fwd1_q <= fwd1;
        fwd2_q <= fwd2;
      end
      if (state == CAPT) begin
        rd_rsp_data1 <= cap1;
        rd_rsp_data2 <= cap2;
      end
    end
  end

endmodule
